// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost behaviour sequencer.
package ghost_pkg;

  // Global ghost mode
  typedef enum logic [1:0] {
    MODE_IDLE    = 2'd0,
    MODE_SCATTER = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_FRIGHT  = 2'd3
  } mode_t;

  // Movement direction shared with the ghost modules
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam int unsigned GHOST_BLINKY = 0;
  localparam int unsigned GHOST_PINKY  = 1;
  localparam int unsigned GHOST_INKY   = 2;
  localparam int unsigned GHOST_CLYDE  = 3;
  localparam int unsigned NUM_GHOSTS   = 4;

  localparam int unsigned SEC_W      = 6;
  localparam int unsigned SEC_MAX    = 63;
  localparam int unsigned PHASE_W    = 3;
  localparam int unsigned PHASE_LAST = 7;

  localparam int unsigned DEF_SCAT0      = 7;
  localparam int unsigned DEF_CHASE0     = 20;
  localparam int unsigned DEF_SCAT1      = 7;
  localparam int unsigned DEF_CHASE1     = 20;
  localparam int unsigned DEF_SCAT2      = 5;
  localparam int unsigned DEF_CHASE2     = 20;
  localparam int unsigned DEF_SCAT3      = 5;
  localparam int unsigned DEF_FRIGHT_SEC = 6;
  localparam int unsigned DEF_FLASH_SEC  = 2;
  localparam int unsigned DEF_REL1       = 5;
  localparam int unsigned DEF_REL2       = 10;
  localparam int unsigned DEF_REL3       = 15;

  // Even phases scatter, odd phases chase
  function automatic mode_t phase_mode(input logic [PHASE_W-1:0] idx);
    return idx[0] ? MODE_CHASE : MODE_SCATTER;
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Cycle prescaler plus saturating 6-bit seconds counter.
module sec_timer
  import ghost_pkg::*;
#(
  parameter int unsigned CYCLES_PER_SEC = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [SEC_W-1:0] secs,
  output logic             sec_tick
);

  localparam int unsigned PRE_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYCLES_PER_SEC - 1);

  logic [PRE_W-1:0] pre;

  // High on the enabled cycle that completes a second
  assign sec_tick = en && (pre == PRE_LAST);

  // Prescaler and seconds count; clear beats enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre  <= '0;
      secs <= '0;
    end else if (clr) begin
      pre  <= '0;
      secs <= '0;
    end else if (en) begin
      if (sec_tick) begin
        pre <= '0;
        if (secs != SEC_W'(SEC_MAX)) secs <= secs + SEC_W'(1);
      end else begin
        pre <= pre + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/ghost_mode_ctrl.sv
// Scatter/chase schedule, frightened override and house release sequencer.
module ghost_mode_ctrl
  import ghost_pkg::*;
#(
  parameter int unsigned CYCLES_PER_SEC = 25_000_000,
  parameter int unsigned SCAT0          = DEF_SCAT0,
  parameter int unsigned CHASE0         = DEF_CHASE0,
  parameter int unsigned SCAT1          = DEF_SCAT1,
  parameter int unsigned CHASE1         = DEF_CHASE1,
  parameter int unsigned SCAT2          = DEF_SCAT2,
  parameter int unsigned CHASE2         = DEF_CHASE2,
  parameter int unsigned SCAT3          = DEF_SCAT3,
  parameter int unsigned FRIGHT_SEC     = DEF_FRIGHT_SEC,
  parameter int unsigned FLASH_SEC      = DEF_FLASH_SEC,
  parameter int unsigned REL1           = DEF_REL1,
  parameter int unsigned REL2           = DEF_REL2,
  parameter int unsigned REL3           = DEF_REL3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               run,
  input  logic               energizer,
  output logic               is_scatter,
  output logic               is_chase,
  output logic               is_frightened,
  output logic               fright_flash,
  output logic               reverse_pulse,
  output logic [PHASE_W-1:0] phase_idx,
  output logic [3:0]         ghost_release
);

  localparam int unsigned FLASH_AT = (FRIGHT_SEC > FLASH_SEC) ? (FRIGHT_SEC - FLASH_SEC) : 0;

  mode_t state, state_nxt;
  logic [PHASE_W-1:0] idx_nxt, idx_adv;
  logic [3:0] rel_nxt;
  logic rev_nxt, flash_nxt;

  logic active, ph_en, fr_en, rel_en, ph_clr, fr_clr, rel_clr;
  logic ph_tick, fr_tick, rel_tick;
  logic [SEC_W-1:0] ph_secs, fr_secs, rel_secs;
  logic [SEC_W-1:0] ph_dur, fr_secs_nxt, rel_secs_nxt;
  logic phase_exp, fright_exp, ener_hit;

  // Duration of the current schedule phase; phase 7 never expires
  always_comb begin
    case (phase_idx)
      3'd0:    ph_dur = SEC_W'(SCAT0);
      3'd1:    ph_dur = SEC_W'(CHASE0);
      3'd2:    ph_dur = SEC_W'(SCAT1);
      3'd3:    ph_dur = SEC_W'(CHASE1);
      3'd4:    ph_dur = SEC_W'(SCAT2);
      3'd5:    ph_dur = SEC_W'(CHASE2);
      3'd6:    ph_dur = SEC_W'(SCAT3);
      default: ph_dur = '0;
    endcase
  end

  assign active   = (state != MODE_IDLE);
  assign ph_en    = run && ((state == MODE_SCATTER) || (state == MODE_CHASE));
  assign fr_en    = run && (state == MODE_FRIGHT);
  assign rel_en   = run && active;
  assign ener_hit = energizer && active;

  assign phase_exp  = ph_tick && (phase_idx != PHASE_W'(PHASE_LAST))
                      && (ph_secs == ph_dur - SEC_W'(1));
  assign fright_exp = fr_tick && (fr_secs == SEC_W'(FRIGHT_SEC - 1));
  assign idx_adv    = phase_exp ? phase_idx + PHASE_W'(1) : phase_idx;

  assign ph_clr  = start || phase_exp;
  assign fr_clr  = start || ener_hit;
  assign rel_clr = start;

  sec_timer #(.CYCLES_PER_SEC(CYCLES_PER_SEC)) u_phase_tmr (
    .clk(clk), .reset(reset), .en(ph_en), .clr(ph_clr), .secs(ph_secs), .sec_tick(ph_tick)
  );

  sec_timer #(.CYCLES_PER_SEC(CYCLES_PER_SEC)) u_fright_tmr (
    .clk(clk), .reset(reset), .en(fr_en), .clr(fr_clr), .secs(fr_secs), .sec_tick(fr_tick)
  );

  sec_timer #(.CYCLES_PER_SEC(CYCLES_PER_SEC)) u_release_tmr (
    .clk(clk), .reset(reset), .en(rel_en), .clr(rel_clr), .secs(rel_secs), .sec_tick(rel_tick)
  );

  // Post-edge seconds values so flash and release bits line up with the counters
  always_comb begin
    fr_secs_nxt = fr_secs;
    if (fr_clr) fr_secs_nxt = '0;
    else if (fr_tick && (fr_secs != SEC_W'(SEC_MAX))) fr_secs_nxt = fr_secs + SEC_W'(1);
    rel_secs_nxt = rel_secs;
    if (rel_clr) rel_secs_nxt = '0;
    else if (rel_tick && (rel_secs != SEC_W'(SEC_MAX))) rel_secs_nxt = rel_secs + SEC_W'(1);
  end

  // Next mode, phase, reverse request and release bits; start > energizer > phase expiry
  always_comb begin
    state_nxt = state;
    idx_nxt   = phase_idx;
    rev_nxt   = 1'b0;
    rel_nxt   = ghost_release;
    if (start) begin
      state_nxt = MODE_SCATTER;
      idx_nxt   = '0;
      rel_nxt   = 4'b0001;
    end else if (active) begin
      idx_nxt = idx_adv;
      if (ener_hit) begin
        state_nxt = MODE_FRIGHT;
        rev_nxt   = 1'b1;
      end else if (phase_exp) begin
        state_nxt = phase_mode(idx_adv);
        rev_nxt   = 1'b1;
      end else if (fright_exp) begin
        state_nxt = phase_mode(phase_idx);
      end
      if (rel_secs_nxt >= SEC_W'(REL1)) rel_nxt[GHOST_PINKY] = 1'b1;
      if (rel_secs_nxt >= SEC_W'(REL2)) rel_nxt[GHOST_INKY]  = 1'b1;
      if (rel_secs_nxt >= SEC_W'(REL3)) rel_nxt[GHOST_CLYDE] = 1'b1;
    end
    flash_nxt = (state_nxt == MODE_FRIGHT) && (fr_secs_nxt >= SEC_W'(FLASH_AT));
  end

  // Mode register with registered decoded outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= MODE_IDLE;
      phase_idx     <= '0;
      ghost_release <= '0;
      reverse_pulse <= 1'b0;
      is_scatter    <= 1'b0;
      is_chase      <= 1'b0;
      is_frightened <= 1'b0;
      fright_flash  <= 1'b0;
    end else begin
      state         <= state_nxt;
      phase_idx     <= idx_nxt;
      ghost_release <= rel_nxt;
      reverse_pulse <= rev_nxt;
      is_scatter    <= (state_nxt == MODE_SCATTER);
      is_chase      <= (state_nxt == MODE_CHASE);
      is_frightened <= (state_nxt == MODE_FRIGHT);
      fright_flash  <= flash_nxt;
    end
  end

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Directed bench for ghost_mode_ctrl with a 4-cycle game second.
module tb_ghost_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, run, energizer;
  logic       is_scatter, is_chase, is_frightened, fright_flash, reverse_pulse;
  logic [2:0] phase_idx;
  logic [3:0] ghost_release;

  int checks = 0;
  int errors = 0;
  int cnt    = 0;

  ghost_mode_ctrl #(.CYCLES_PER_SEC(4)) dut (
    .clk(clk), .reset(reset), .start(start), .run(run), .energizer(energizer),
    .is_scatter(is_scatter), .is_chase(is_chase), .is_frightened(is_frightened),
    .fright_flash(fright_flash), .reverse_pulse(reverse_pulse),
    .phase_idx(phase_idx), .ghost_release(ghost_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mode(input string tag, input logic sc, input logic ch, input logic fr);
    chk({tag, ".scatter"}, 32'(is_scatter), 32'(sc));
    chk({tag, ".chase"}, 32'(is_chase), 32'(ch));
    chk({tag, ".fright"}, 32'(is_frightened), 32'(fr));
  endtask

  // One clock edge, then sample 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
    cnt++;
  endtask

  task automatic run_to(input int t);
    while (cnt < t) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt   = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; run = 1'b1; energizer = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_mode("reset", 0, 0, 0);
    chk("reset.idx", 32'(phase_idx), 0);
    chk("reset.rel", 32'(ghost_release), 0);
    chk("reset.rev", 32'(reverse_pulse), 0);
    reset = 1'b0;
    tick();

    // Energizer while idle does nothing
    energizer = 1'b1; tick(); energizer = 1'b0;
    chk_mode("idle_ener", 0, 0, 0);
    chk("idle_ener.rev", 32'(reverse_pulse), 0);
    tick();
    chk("idle.rel", 32'(ghost_release), 0);

    // Start, release schedule and phase schedule
    pulse_start();
    chk_mode("start", 1, 0, 0);
    chk("start.idx", 32'(phase_idx), 0);
    chk("start.rel", 32'(ghost_release), 4'b0001);
    run_to(19); chk("rel19", 32'(ghost_release), 4'b0001);
    run_to(20); chk("rel20", 32'(ghost_release), 4'b0011);
    run_to(27); chk_mode("c27", 1, 0, 0); chk("c27.rev", 32'(reverse_pulse), 0);
    run_to(28); chk_mode("c28", 0, 1, 0); chk("c28.rev", 32'(reverse_pulse), 1);
    chk("c28.idx", 32'(phase_idx), 1);
    run_to(29); chk("c29.rev", 32'(reverse_pulse), 0);
    run_to(39); chk("rel39", 32'(ghost_release), 4'b0011);
    run_to(40); chk("rel40", 32'(ghost_release), 4'b0111);
    run_to(59); chk("rel59", 32'(ghost_release), 4'b0111);
    run_to(60); chk("rel60", 32'(ghost_release), 4'b1111);
    run_to(107); chk("c107.idx", 32'(phase_idx), 1);
    run_to(108); chk("c108.idx", 32'(phase_idx), 2); chk_mode("c108", 1, 0, 0);
    chk("c108.rev", 32'(reverse_pulse), 1);
    run_to(335); chk("c335.idx", 32'(phase_idx), 6); chk_mode("c335", 1, 0, 0);
    run_to(336); chk("c336.idx", 32'(phase_idx), 7); chk_mode("c336", 0, 1, 0);
    chk("c336.rev", 32'(reverse_pulse), 1);
    run_to(356); chk("c356.idx", 32'(phase_idx), 7); chk_mode("c356", 0, 1, 0);
    run_to(600); chk("c600.idx", 32'(phase_idx), 7); chk_mode("c600", 0, 1, 0);
    chk("c600.rev", 32'(reverse_pulse), 0);
    chk("c600.rel", 32'(ghost_release), 4'b1111);

    // Frightened override 10 cycles into phase 0 (restart from chase-forever)
    pulse_start();
    chk_mode("f.start", 1, 0, 0);
    chk("f.start.rel", 32'(ghost_release), 4'b0001);
    run_to(9); energizer = 1'b1; run_to(10); energizer = 1'b0;
    chk_mode("f10", 0, 0, 1); chk("f10.rev", 32'(reverse_pulse), 1);
    chk("f10.flash", 32'(fright_flash), 0);
    run_to(11); chk("f11.rev", 32'(reverse_pulse), 0);
    run_to(20); chk("f20.rel", 32'(ghost_release), 4'b0011);
    run_to(25); chk("f25.flash", 32'(fright_flash), 0); chk_mode("f25", 0, 0, 1);
    run_to(26); chk("f26.flash", 32'(fright_flash), 1);
    run_to(33); chk("f33.flash", 32'(fright_flash), 1); chk_mode("f33", 0, 0, 1);
    run_to(34); chk_mode("f34", 1, 0, 0); chk("f34.flash", 32'(fright_flash), 0);
    chk("f34.rev", 32'(reverse_pulse), 0); chk("f34.idx", 32'(phase_idx), 0);
    run_to(51); chk_mode("f51", 1, 0, 0);
    run_to(52); chk_mode("f52", 0, 1, 0); chk("f52.rev", 32'(reverse_pulse), 1);

    // Second energizer 12 cycles into fright restarts the fright timer
    pulse_start();
    run_to(9); energizer = 1'b1; run_to(10); energizer = 1'b0;
    run_to(21); chk("r21.rev", 32'(reverse_pulse), 0);
    energizer = 1'b1; run_to(22); energizer = 1'b0;
    chk("r22.rev", 32'(reverse_pulse), 1); chk_mode("r22", 0, 0, 1);
    run_to(23); chk("r23.rev", 32'(reverse_pulse), 0);
    run_to(34); chk_mode("r34", 0, 0, 1);
    run_to(37); chk("r37.flash", 32'(fright_flash), 0);
    run_to(38); chk("r38.flash", 32'(fright_flash), 1);
    run_to(45); chk_mode("r45", 0, 0, 1);
    run_to(46); chk_mode("r46", 1, 0, 0); chk("r46.rev", 32'(reverse_pulse), 0);
    run_to(63); chk_mode("r63", 1, 0, 0);
    run_to(64); chk_mode("r64", 0, 1, 0);

    // Pause for 50 cycles mid-phase: nothing moves, expiries shift
    pulse_start();
    run_to(10);
    run = 1'b0;
    repeat (50) begin @(posedge clk); #1; end
    chk_mode("p.held", 1, 0, 0);
    chk("p.held.idx", 32'(phase_idx), 0);
    chk("p.held.rel", 32'(ghost_release), 4'b0001);
    run = 1'b1;
    run_to(19); chk("p19.rel", 32'(ghost_release), 4'b0001);
    run_to(20); chk("p20.rel", 32'(ghost_release), 4'b0011);
    run_to(27); chk_mode("p27", 1, 0, 0);
    run_to(28); chk_mode("p28", 0, 1, 0); chk("p28.rev", 32'(reverse_pulse), 1);

    // Energizer coincident with phase-0 expiry
    pulse_start();
    run_to(27); energizer = 1'b1; run_to(28); energizer = 1'b0;
    chk("x28.idx", 32'(phase_idx), 1); chk_mode("x28", 0, 0, 1);
    chk("x28.rev", 32'(reverse_pulse), 1);
    run_to(29); chk("x29.rev", 32'(reverse_pulse), 0);
    run_to(51); chk_mode("x51", 0, 0, 1);
    run_to(52); chk_mode("x52", 0, 1, 0); chk("x52.idx", 32'(phase_idx), 1);
    chk("x52.rev", 32'(reverse_pulse), 0);

    // Asynchronous reset in the middle of fright
    pulse_start();
    run_to(9); energizer = 1'b1; run_to(10); energizer = 1'b0;
    run_to(28);
    chk("a28.flash", 32'(fright_flash), 1);
    #2 reset = 1'b1;
    #1;
    chk_mode("areset", 0, 0, 0);
    chk("areset.flash", 32'(fright_flash), 0);
    chk("areset.idx", 32'(phase_idx), 0);
    chk("areset.rel", 32'(ghost_release), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    chk_mode("post_reset", 0, 0, 0);
    chk("post_reset.rev", 32'(reverse_pulse), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
